// File: rtl/sram_mem_controller.sv
// MEM-stage SRAM sequencer: splits each 32-bit load/store into two 16-bit
// asynchronous-SRAM transactions (low half, then high half) and holds the
// pipeline via `ready` until the access completes.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WW = SRAM_AW - 1;
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_write_q, is_write_d;
  logic [WW-1:0]      word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        lo_buf_q, lo_buf_d;
  logic [31:0]        read_data_d;
  logic [SRAM_AW-1:0] sram_addr_d;
  logic [15:0]        sram_dq_out_d;
  logic               sram_dq_oe_d, sram_we_n_d;

  logic [31:0]        off;
  logic [WW-1:0]      req_word;
  logic               unused_off_bits;

  assign off      = address - 32'(BASE_ADDR);
  assign req_word = off[SRAM_AW:2];
  // Byte offset and out-of-range upper bits are dropped by design.
  assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

  // Pipeline may advance when no memory op is pending or the access is finishing.
  assign ready = ~(mem_read | mem_write) | (state_q == DONE);

  // State, latched request and registered SRAM-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      lo_buf_q    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      lo_buf_q    <= lo_buf_d;
      read_data   <= read_data_d;
      sram_addr   <= sram_addr_d;
      sram_dq_out <= sram_dq_out_d;
      sram_dq_oe  <= sram_dq_oe_d;
      sram_we_n   <= sram_we_n_d;
    end
  end

  // Next state plus the SRAM pin values for the phase being entered, so the
  // bus pins are glitch-free registers rather than decoded from state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_write_d    = is_write_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    lo_buf_d      = lo_buf_q;
    read_data_d   = read_data;
    sram_addr_d   = sram_addr;
    sram_dq_out_d = sram_dq_out;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (mem_write | mem_read) begin
          state_d     = LOW;
          cnt_d       = RELOAD;
          is_write_d  = mem_write;
          word_d      = req_word;
          wdata_d     = write_data;
          sram_addr_d = {req_word, 1'b0};
          if (mem_write) begin
            sram_dq_oe_d  = 1'b1;
            sram_we_n_d   = 1'b0;
            sram_dq_out_d = write_data[15:0];
          end
        end
      end
      LOW: begin
        sram_dq_oe_d = is_write_q;
        sram_we_n_d  = ~is_write_q;
        if (cnt_q == '0) begin
          state_d     = HIGH;
          cnt_d       = RELOAD;
          sram_addr_d = {word_q, 1'b1};
          if (is_write_q) sram_dq_out_d = wdata_q[31:16];
          else            lo_buf_d      = sram_dq_in;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!is_write_q) read_data_d = {sram_dq_in, lo_buf_q};
        end else begin
          sram_dq_oe_d = is_write_q;
          sram_we_n_d  = ~is_write_q;
          cnt_d        = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (WAIT_CYCLES 1 and 3), each with
// an SRAM model, a driver that pushes expected results and a monitor that
// compares them when the controller signals completion.
module tb_sram_mem_controller;

  localparam int unsigned AW = 18;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we_n;
    logic          oe;
    logic [15:0]   dq;
  } bus_t;

  typedef struct {
    bit          wr;
    int unsigned word;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          issue;
  } exp_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] init_val(input int unsigned i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  // CPU byte address -> 32-bit word index in SRAM (halfword pair), truncated.
  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off / 4) % (1 << 17);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int unsigned W = (g == 0) ? 1 : 3;

    logic              rst, mem_read, mem_write, ready, sram_dq_oe, sram_we_n;
    logic [31:0]       address, write_data, read_data;
    logic [AW-1:0]     sram_addr, last_addr;
    logic [15:0]       sram_dq_out, sram_dq_in;
    logic [15:0]       sram [0:(1<<AW)-1];
    int unsigned       age;
    logic [15:0]       ref_hw [int unsigned];
    logic [31:0]       last_read;
    exp_t              q[$];
    bus_t              obs[$];
    bit                done = 1'b0;

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    // Data is only valid once the address has been stable for W cycles.
    assign sram_dq_in = (age >= W - 1) ? sram[sram_addr] : ~sram[sram_addr];

    // Asynchronous SRAM model: access-time tracking and write on strobe.
    initial begin
      for (int unsigned i = 0; i < (1 << AW); i++) sram[i] = init_val(i);
      sram[2] = 16'h5678;
      sram[3] = 16'h1234;
      age = 0;
      last_addr = '0;
      forever begin
        @(negedge clk);
        if (sram_addr == last_addr) age++;
        else age = 0;
        last_addr = sram_addr;
        if (!sram_we_n) sram[sram_addr] = sram_dq_oe ? sram_dq_out : 16'h0BAD;
      end
    end

    function automatic logic [15:0] ref_get(input int unsigned i);
      if (ref_hw.exists(i)) return ref_hw[i];
      return init_val(i);
    endfunction

    // Present one request (just after a posedge) and hold it until ready.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   n;
      mem_write  = wr;
      mem_read   = rd;
      address    = a;
      write_data = d;
      e.wr    = wr;
      e.word  = word_of(a);
      e.data  = d;
      e.issue = cyc;
      if (wr) begin
        ref_hw[2*e.word]   = d[15:0];
        ref_hw[2*e.word+1] = d[31:16];
      end else begin
        last_read = {ref_get(2*e.word+1), ref_get(2*e.word)};
      end
      e.exp_rd = last_read;
      q.push_back(e);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ready && n < 40);
      if (!ready) check($sformatf("W%0d ready timeout", W), 64'd0, 64'd1);
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    // Monitor: idle-bus checks, per-access bus trace, completion scoreboard.
    always @(negedge clk) begin
      exp_t          e;
      bit            ok, hi;
      logic [AW-1:0] ea;
      if (rst) begin
        obs.delete();
      end else if (!(mem_read || mem_write)) begin
        check($sformatf("W%0d idle ready", W), 64'(ready), 64'd1);
        check($sformatf("W%0d idle strobes", W), 64'({sram_we_n, sram_dq_oe}), 64'b10);
      end else if (q.size() > 0) begin
        if (!ready) begin
          if (cyc > q[0].issue) obs.push_back({sram_addr, sram_we_n, sram_dq_oe, sram_dq_out});
        end else begin
          e = q.pop_front();
          check($sformatf("W%0d latency", W), 64'(cyc), 64'(e.issue + 2*W + 1));
          check($sformatf("W%0d read_data", W), 64'(read_data), 64'(e.exp_rd));
          check($sformatf("W%0d done strobes", W), 64'({sram_we_n, sram_dq_oe}), 64'b10);
          check($sformatf("W%0d bus length", W), 64'(obs.size()), 64'(2*W));
          ok = 1'b1;
          foreach (obs[k]) begin
            hi = (k >= W);
            ea = AW'(2*e.word + 32'(hi));
            if (obs[k].addr !== ea) ok = 1'b0;
            if (e.wr) begin
              if (obs[k].we_n !== 1'b0 || obs[k].oe !== 1'b1 ||
                  obs[k].dq !== (hi ? e.data[31:16] : e.data[15:0])) ok = 1'b0;
            end else if (obs[k].we_n !== 1'b1 || obs[k].oe !== 1'b0) begin
              ok = 1'b0;
            end
          end
          check($sformatf("W%0d bus sequence word 0x%0h", W, e.word), 64'(ok), 64'd1);
          obs.delete();
        end
      end
    end

    // Driver: directed cases, mid-write reset, then randomized traffic.
    initial begin
      int unsigned kind, r;
      logic [31:0] a, d;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      address = '0; write_data = '0; last_read = '0;
      ref_hw[2] = 16'h5678;
      ref_hw[3] = 16'h1234;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("W%0d reset read_data", W), 64'(read_data), 64'd0);
      check($sformatf("W%0d reset sram_addr", W), 64'(sram_addr), 64'd0);
      check($sformatf("W%0d reset dq_out", W), 64'(sram_dq_out), 64'd0);
      check($sformatf("W%0d reset strobes", W), 64'({sram_we_n, sram_dq_oe}), 64'b10);
      rst = 1'b0;
      idle(10);

      access(1'b0, 1'b1, 32'd1028, 32'd0);
      access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
      idle(1);
      access(1'b1, 1'b0, 32'd1040, 32'hA5C3_1E0F);
      access(1'b0, 1'b1, 32'd1040, 32'd0);
      access(1'b1, 1'b1, 32'd1044, 32'h0BB0_7117);
      access(1'b0, 1'b1, 32'd1046, 32'd0);
      idle(2);

      // Reset during the first cycle of a write: only the low half lands.
      mem_write = 1'b1; address = 32'd1060; write_data = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      rst = 1'b1; mem_write = 1'b0;
      ref_hw[2*word_of(32'd1060)] = 16'hF00D;
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_read = '0;
      check($sformatf("W%0d abort read_data", W), 64'(read_data), 64'd0);
      check($sformatf("W%0d abort strobes", W), 64'({sram_we_n, sram_dq_oe}), 64'b10);
      idle(3);
      access(1'b0, 1'b1, 32'd1060, 32'd0);
      idle(1);

      for (int i = 0; i < 40; i++) begin
        kind = $urandom_range(0, 2);
        r    = $urandom_range(0, 9);
        d    = $urandom();
        if (r == 0)      a = 32'd1024 - 32'(4 * $urandom_range(1, 4));
        else if (r == 1) a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + (32'd1 << 19) * 32'($urandom_range(1, 3));
        else             a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        access(kind != 0, kind != 1, a, d);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(3);
      check($sformatf("W%0d pending expectations", W), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(h[0].done && h[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(h[0].done && h[1].done)) check("run timeout", 64'd0, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
